stlatch_bank: RTL and testbench

Multi-channel, parametrised successor to the single clock-domain latch model. Provides CHANNELS independent latch channels of WIDTH bits, each with set, reset and gate inputs. A per-channel mode selects transparent, rising-gate-capture, falling-gate-capture or frozen behaviour. Each channel also emits a one-cycle change flag. It sits in gstmcu wherever groups of ST-chip latches (register files, bus-hold latches, strobe-captured fields) are modelled inside the synchronous `clock` domain.

---
 rtl/stlatch_pkg.sv | 13 +
 rtl/stlatch_chan.sv | 75 +++++++
 rtl/stlatch_bank.sv | 50 +++++
 tb/tb_stlatch_bank.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/stlatch_pkg.sv
// -----------------------------------------------------------------------------
// stlatch_pkg
// Shared definitions for the ST-chip latch bank: per-channel mode encoding.
// Ports: none (package).
// -----------------------------------------------------------------------------
package stlatch_pkg;

   localparam logic [1:0] MODE_TRANSPARENT = 2'b00;
   localparam logic [1:0] MODE_RISE        = 2'b01;
   localparam logic [1:0] MODE_FALL        = 2'b10;
   localparam logic [1:0] MODE_FROZEN      = 2'b11;

endpackage

// File: rtl/stlatch_chan.sv
// -----------------------------------------------------------------------------
// stlatch_chan
// One latch channel modelled inside the synchronous clock domain. The output
// is combinational so that transparent and edge-cycle paths have zero latency;
// the stored value is the output sampled at each clock edge.
// Ports:
//   clock   - system clock
//   reset   - asynchronous, active-high clear of all channel state
//   s, r    - set / reset (r has priority), valid in every mode
//   g       - gate
//   mode    - 00 transparent, 01 rising capture, 10 falling capture, 11 frozen
//   d       - data in
//   q       - latch output
//   changed - one-cycle pulse after the stored value changes
// -----------------------------------------------------------------------------
module stlatch_chan
   import stlatch_pkg::*;
#(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] SET_VAL   = WIDTH'(1),
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             s,
   input  logic             r,
   input  logic             g,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             changed
);

   logic [WIDTH-1:0] hold;
   logic             g_prev;
   logic             rise_edge;
   logic             fall_edge;

   // Edge windows last only the cycle where g differs from its last sample.
   assign rise_edge = g & ~g_prev;
   assign fall_edge = ~g & g_prev;

   always_comb begin
      q = hold;
      if (reset) begin
         q = RESET_VAL;
      end else if (r) begin
         q = RESET_VAL;
      end else if (s) begin
         q = SET_VAL;
      end else begin
         case (mode)
            MODE_TRANSPARENT: q = g ? d : hold;
            MODE_RISE:        q = rise_edge ? d : hold;
            MODE_FALL:        q = fall_edge ? d : hold;
            MODE_FROZEN:      q = hold;
         endcase
      end
   end

   // g_prev tracks the gate in every mode so switching mode never sees a
   // stale edge; a capture lost to s/r is therefore not retried.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hold    <= RESET_VAL;
         g_prev  <= 1'b0;
         changed <= 1'b0;
      end else begin
         hold    <= q;
         g_prev  <= g;
         changed <= (q != hold);
      end
   end

endmodule

// File: rtl/stlatch_bank.sv
// -----------------------------------------------------------------------------
// stlatch_bank
// CHANNELS independent latch channels of WIDTH bits each. This level only
// slices the packed buses onto the per-channel instances.
// Ports:
//   clock   - system clock
//   reset   - asynchronous, active-high clear of every channel
//   s, r, g - per-channel set, reset, gate (bit i -> channel i)
//   mode    - per-channel mode, channel i uses [2i+1:2i]
//   d, q    - per-channel data in / out, channel i uses [WIDTH*i +: WIDTH]
//   changed - per-channel change pulse
// -----------------------------------------------------------------------------
module stlatch_bank
   import stlatch_pkg::*;
#(
   parameter int               WIDTH     = 1,
   parameter int               CHANNELS  = 4,
   parameter logic [WIDTH-1:0] SET_VAL   = WIDTH'(1),
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [CHANNELS-1:0]       s,
   input  logic [CHANNELS-1:0]       r,
   input  logic [CHANNELS-1:0]       g,
   input  logic [2*CHANNELS-1:0]     mode,
   input  logic [CHANNELS*WIDTH-1:0] d,
   output logic [CHANNELS*WIDTH-1:0] q,
   output logic [CHANNELS-1:0]       changed
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      stlatch_chan #(
         .WIDTH     (WIDTH),
         .SET_VAL   (SET_VAL),
         .RESET_VAL (RESET_VAL)
      ) u_chan (
         .clock   (clock),
         .reset   (reset),
         .s       (s[i]),
         .r       (r[i]),
         .g       (g[i]),
         .mode    (mode[2*i +: 2]),
         .d       (d[WIDTH*i +: WIDTH]),
         .q       (q[WIDTH*i +: WIDTH]),
         .changed (changed[i])
      );
   end

endmodule

// File: tb/tb_stlatch_bank.sv
// -----------------------------------------------------------------------------
// tb_stlatch_bank
// Self-checking bench for stlatch_bank (WIDTH=8, CHANNELS=4): directed
// scenarios followed by randomized traffic against a behavioural model.
// -----------------------------------------------------------------------------
module tb_stlatch_bank;

   localparam int W = 8;
   localparam int C = 4;

   logic           clock;
   logic           reset;
   logic [C-1:0]   s;
   logic [C-1:0]   r;
   logic [C-1:0]   g;
   logic [2*C-1:0] mode;
   logic [C*W-1:0] d;
   logic [C*W-1:0] q;
   logic [C-1:0]   changed;

   int checks = 0;
   int errors = 0;

   // Behavioural model state per channel
   logic [W-1:0] m_hold [C];
   logic         m_gp   [C];
   logic         m_chg  [C];

   stlatch_bank #(
      .WIDTH     (W),
      .CHANNELS  (C),
      .SET_VAL   (8'h01),
      .RESET_VAL (8'h00)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .s       (s),
      .r       (r),
      .g       (g),
      .mode    (mode),
      .d       (d),
      .q       (q),
      .changed (changed)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_q(input int i);
      logic [1:0]   md;
      logic         gi;
      logic [W-1:0] di;
      md = mode[2*i +: 2];
      gi = g[i];
      di = d[W*i +: W];
      if (reset || r[i]) return 8'h00;
      if (s[i])          return 8'h01;
      case (md)
         2'd0:    return gi ? di : m_hold[i];
         2'd1:    return (gi && !m_gp[i]) ? di : m_hold[i];
         2'd2:    return (!gi && m_gp[i]) ? di : m_hold[i];
         default: return m_hold[i];
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < C; i++) begin
         m_hold[i] = '0;
         m_gp[i]   = 1'b0;
         m_chg[i]  = 1'b0;
      end
   endtask

   // Advance one clock: model takes the values seen just before the edge,
   // then returns at the following falling edge.
   task automatic tick();
      logic [W-1:0] nq [C];
      for (int i = 0; i < C; i++) nq[i] = ref_q(i);
      @(posedge clock);
      if (reset) begin
         model_reset();
      end else begin
         for (int i = 0; i < C; i++) begin
            m_chg[i]  = (nq[i] != m_hold[i]);
            m_hold[i] = nq[i];
            m_gp[i]   = g[i];
         end
      end
      @(negedge clock);
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < C; i++) begin
         check($sformatf("%s_q%0d", tag, i), 32'(q[W*i +: W]), 32'(ref_q(i)));
         check($sformatf("%s_chg%0d", tag, i), 32'(changed[i]), 32'(m_chg[i]));
      end
   endtask

   task automatic set_ch(input int ch, input logic [1:0] m, input logic gg, input logic [W-1:0] dd);
      mode[2*ch +: 2] = m;
      g[ch]           = gg;
      d[W*ch +: W]    = dd;
   endtask

   initial begin
      reset = 1'b1;
      s = '0; r = '0; g = '0; mode = '0; d = '0;
      model_reset();

      // Reset state
      @(negedge clock);
      @(negedge clock);
      check("rst_q", 32'(q), 32'h0);
      check("rst_chg", 32'(changed), 32'h0);
      reset = 1'b0;
      #1 check_all("post_rst");

      // Transparent
      set_ch(0, 2'b00, 1'b1, 8'hA5);
      #1 check("tr_q0", 32'(q[7:0]), 32'hA5);
      tick();
      check("tr_chg0", 32'(changed[0]), 32'h1);
      set_ch(0, 2'b00, 1'b0, 8'h3C);
      #1 check("tr_hold_q0", 32'(q[7:0]), 32'hA5);
      check_all("tr");
      tick();

      // Rising capture
      set_ch(1, 2'b01, 1'b0, 8'h00);
      repeat (3) tick();
      set_ch(1, 2'b01, 1'b1, 8'h11);
      #1 check("rise_q1", 32'(q[15:8]), 32'h11);
      tick();
      check("rise_chg1", 32'(changed[1]), 32'h1);
      d[15:8] = 8'h22;
      #1 check("rise_hold_q1", 32'(q[15:8]), 32'h11);
      tick();
      check("rise_chg1_once", 32'(changed[1]), 32'h0);
      check_all("rise");

      // Falling capture
      set_ch(2, 2'b10, 1'b1, 8'h77);
      #1 check("fall_norise_q2", 32'(q[23:16]), 32'h00);
      tick();
      set_ch(2, 2'b10, 1'b0, 8'h5A);
      #1 check("fall_q2", 32'(q[23:16]), 32'h5A);
      tick();
      d[23:16] = 8'h00;
      #1 check("fall_hold_q2", 32'(q[23:16]), 32'h5A);
      check_all("fall");

      // Priority and frozen
      set_ch(3, 2'b00, 1'b1, 8'h99);
      s[3] = 1'b1; r[3] = 1'b1;
      #1 check("prio_sr_q3", 32'(q[31:24]), 32'h00);
      r[3] = 1'b0;
      #1 check("prio_s_q3", 32'(q[31:24]), 32'h01);
      tick();
      s[3] = 1'b0;
      set_ch(3, 2'b11, 1'b0, 8'hFF);
      for (int k = 0; k < 4; k++) begin
         g[3] = ~g[3];
         #1 check("frozen_q3", 32'(q[31:24]), 32'h01);
         tick();
      end

      // Async reset mid-operation, then rising capture on the first cycle out
      set_ch(0, 2'b11, 1'b1, 8'h3C);
      tick();
      check("pre_rst_nonzero", 32'(q[7:0] != 0 && q[15:8] != 0 && q[23:16] != 0 && q[31:24] != 0), 32'h1);
      #2 reset = 1'b1;
      model_reset();
      #1 check("async_q", 32'(q), 32'h0);
      check("async_chg", 32'(changed), 32'h0);
      tick();
      reset = 1'b0;
      set_ch(0, 2'b01, 1'b1, 8'hC3);
      #1 check("rst_rise_q0", 32'(q[7:0]), 32'hC3);
      check_all("rst_rise");
      tick();

      // Mode switch with gate held high: no capture
      set_ch(1, 2'b00, 1'b1, 8'h44);
      tick();
      set_ch(1, 2'b01, 1'b1, 8'h55);
      #1 check("msw_q1", 32'(q[15:8]), 32'h44);
      check_all("msw");
      tick();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < C; i++) begin
            s[i] = ($urandom_range(0, 7) == 0);
            r[i] = ($urandom_range(0, 9) == 0);
            g[i] = ($urandom_range(0, 2) == 0) ? ~g[i] : g[i];
            if ($urandom_range(0, 15) == 0) mode[2*i +: 2] = 2'($urandom_range(0, 3));
            d[W*i +: W] = 8'($urandom);
         end
         reset = 1'b0;
         #1 check_all("rnd");
         if ($urandom_range(0, 49) == 0) begin
            #1 reset = 1'b1;
            model_reset();
            #1 check_all("rnd_rst");
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
